digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised multi-cycle adder/subtractor. It is the successor to the team's fixed 4-bit combinational ripple adder. Operands of WIDTH bits are accepted through a valid/ready handshake and processed DIGIT bits per clock, least-significant digit first, with a registered carry between digits. The result is held behind an output valid/ready handshake. It sits between operand producers and result consumers where area matters more than latency, and supports add, subtract, carry/borrow chaining and signed-overflow detection.

## Interface
- WIDTH, default 16: operand and result width in bits. Must be ≥ 1.
- DIGIT, default 4: bits processed per cycle. DIGIT must divide WIDTH; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: digit counter 0..NDIG−1.
  - DONE: out_valid=1.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered.
- IDLE→RUN on in_valid && in_ready. Captured values:
  - A register ← a.
  - B register ← sub ? ~b : b.
  - carry ← sub ? ~cin : cin. Subtraction is therefore A + ~B + ~cin.
  - Digit counter cleared.
- RUN, each cycle:
  - Add the low DIGIT bits of the A and B shift registers plus carry, as a (DIGIT+1)-bit addition.
  - Shift the A and B registers right by DIGIT.
  - Shift the DIGIT-bit digit sum into the sum register from the MSB end, so that after NDIG cycles sum is aligned.
  - carry ← digit carry-out.
- On the last digit (counter==NDIG−1):
  - cout ← carry out of bit WIDTH−1.
  - ovf ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - State → DONE.
- DONE→IDLE on out_valid && out_ready.
- sum, cout and ovf hold stable from the DONE entry edge until the next RUN begins. The sum shift register may show partial values during RUN; consumers qualify with out_valid.
- in_valid outside IDLE is ignored. The operand inputs need only be stable on the accept edge.
- DIGIT==WIDTH (NDIG=1) is legal: one RUN cycle.

## Timing
- Reset (async assert, sync deassert by system): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, internal registers 0, digit counter 0.
- Latency: operands accepted at edge E0; out_valid rises after edge E0+NDIG (RUN occupies NDIG cycles).
- Result handshake completes at the edge where out_valid && out_ready. in_ready is 1 in the following cycle.
- Minimum initiation interval: NDIG+2 cycles per operation, assuming out_ready is held high.
- out_ready low: the block stays in DONE indefinitely with outputs stable. No new operand is accepted.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately, all outputs take their reset values, and no out_valid pulse is produced.
- No combinational path from in_valid or out_ready to any output.

## Test plan
With WIDTH=16, DIGIT=4 unless stated otherwise:
1. a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 edges after the accept edge. in_ready=0 throughout RUN and DONE.
2. a=0xFFFF, b=0x0001, cin=0, add → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Then a=0x0000, b=0x0000, cin=1 → sum=0x0001.
3. Subtract: a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. a=0x0009, b=0x0003, cin=1 → sum=0x0005, cout=1.
4. Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held high and new operands → sum/cout/ovf unchanged and in_ready=0. Raise out_ready for one cycle → out_valid falls next cycle, in_ready=1, and the pending operands are accepted on that cycle's edge.
5. Reset mid-operation: assert rst_n=0 after 2 RUN cycles → outputs immediately 0, in_ready=1. Release and run case 1 → correct result with normal latency.
6. Parameter sweep: WIDTH/DIGIT ∈ {16/1, 16/16, 32/8, 8/2, 1/1}, 1000 random operands each with random sub, cin and out_ready stalls → sum/cout/ovf match a reference model. Latency = NDIG edges in every case.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// least-significant digit first, with a registered carry between digits.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit added per cycle, cnt_q = digit index
// DONE  | result held, out_valid high until consumed
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             load, step, last;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] a_shift, b_shift, sum_shift;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   dsum;
    logic             cin_msb;

    assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // carry into the digit's top bit; on the last digit this is the carry into bit WIDTH-1
    assign cin_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    assign last    = (cnt_q == LAST);

    generate
        if (NDIG == 1) begin : g_one
            assign a_shift   = '0;
            assign b_shift   = '0;
            assign sum_shift = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
            assign b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
            assign sum_shift = {dsum[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // subtraction runs as A + ~B + ~cin, so cout=1 means no borrow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ^ cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_shift;
            b_q     <= b_shift;
            sum_q   <= sum_shift;
            carry_q <= dsum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= dsum[DIGIT];
                ovf_q  <= cin_msb ^ dsum[DIGIT];
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed cases on a 16/4 instance plus random
// sweeps on five other geometries, all checked through expected-result queues.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst0_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not seen, got 0 expected 1 (cycle %0d)", name, cyc);
    endtask

    // Reference: signed/unsigned integer arithmetic on the true operand values.
    function automatic exp_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input logic sub, input int t);
        exp_t        e;
        longint      sa, sb, tr, lo, hi;
        logic [63:0] u, m;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        tr = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        u  = sub ? (a - b - 64'(cin)) : (a + b + 64'(cin));
        e.sum  = u & m;
        e.cout = sub ? (a >= b + 64'(cin)) : ((u >> w) != 64'd0);
        e.ovf  = (tr < lo) || (tr > hi);
        e.t    = t;
        return e;
    endfunction

    // ---------------- directed instance, WIDTH=16 DIGIT=4 ----------------
    logic        d_iv, d_ir, d_cin, d_sub, d_ov, d_ordy, d_co, d_of;
    logic [15:0] d_a, d_b, d_sum;
    exp_t        q0[$];
    bit          seen0 = 0;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst_n(rst0_n), .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(d_ov), .out_ready(d_ordy), .sum(d_sum), .cout(d_co), .ovf(d_of)
    );

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst0_n) begin
                seen0 = 0;
            end else if (d_ov) begin
                if (q0.size() == 0) begin
                    fail_now("dir_unexpected_valid");
                end else begin
                    if (!seen0) begin
                        chk("dir_latency", 64'(cyc), 64'(q0[0].t + 4));
                        seen0 = 1;
                    end
                    if (d_ordy) begin
                        e = q0.pop_front();
                        chk("dir_sum", 64'(d_sum), e.sum);
                        chk("dir_cout", 64'(d_co), 64'(e.cout));
                        chk("dir_ovf", 64'(d_of), 64'(e.ovf));
                        seen0 = 0;
                    end
                end
            end
        end
    end

    task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int k = 0;
        d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_iv = 1'b1;
        while (!d_ir && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!d_ir) fail_now("dir_accept_timeout");
        else q0.push_back(ref_model(16, 64'(a), 64'(b), cin, sub, cyc + 1));
        @(negedge clk);
        d_iv = 1'b0;
    endtask

    task automatic wait_idle0();
        int k = 0;
        while (!(q0.size() == 0 && d_ir) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!(q0.size() == 0 && d_ir)) fail_now("dir_drain_timeout");
    endtask

    // ---------------- random sweep instances ----------------
    function automatic int sw_w(input int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 32;
            3: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int sw_d(input int i);
        case (i)
            0: return 1;
            1: return 16;
            2: return 8;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_sw
            localparam int W = sw_w(gi);
            localparam int D = sw_d(gi);
            localparam int N = W / D;
            logic         iv, ir, ov, ci, sb, co, of;
            logic         ordy = 1'b1;
            logic [W-1:0] ai, bi, so;
            exp_t         q[$];
            bit           seen = 0;
            bit           done = 0;

            digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
                .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
                .a(ai), .b(bi), .cin(ci), .sub(sb),
                .out_valid(ov), .out_ready(ordy), .sum(so), .cout(co), .ovf(of)
            );

            initial begin
                logic [63:0] ra, rb;
                int k;
                iv = 1'b0; ai = '0; bi = '0; ci = 1'b0; sb = 1'b0;
                while (!rst_n) @(negedge clk);
                for (int n = 0; n < 1000; n++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 7) == 0) @(negedge clk);
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    ai = ra[W-1:0];
                    bi = rb[W-1:0];
                    ci = 1'($urandom);
                    sb = 1'($urandom);
                    iv = 1'b1;
                    k = 0;
                    while (!ir && k < 200) begin
                        @(negedge clk);
                        k++;
                    end
                    if (!ir) fail_now($sformatf("sw%0d_accept_timeout", gi));
                    else q.push_back(ref_model(W, 64'(ai), 64'(bi), ci, sb, cyc + 1));
                    @(negedge clk);
                    iv = 1'b0;
                end
                k = 0;
                while (q.size() != 0 && k < 1000) begin
                    @(negedge clk);
                    k++;
                end
                if (q.size() != 0) fail_now($sformatf("sw%0d_drain_timeout", gi));
                done = 1;
            end

            initial begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    ordy = ($urandom_range(0, 3) != 0);
                    if (ov) begin
                        if (q.size() == 0) begin
                            fail_now($sformatf("sw%0d_unexpected_valid", gi));
                        end else begin
                            if (!seen) begin
                                chk($sformatf("sw%0d_latency", gi), 64'(cyc), 64'(q[0].t + N));
                                seen = 1;
                            end
                            if (ordy) begin
                                e = q.pop_front();
                                chk($sformatf("sw%0d_sum", gi), 64'(so), e.sum);
                                chk($sformatf("sw%0d_cout", gi), 64'(co), 64'(e.cout));
                                chk($sformatf("sw%0d_ovf", gi), 64'(of), 64'(e.ovf));
                                seen = 0;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // ---------------- directed sequence and wrap-up ----------------
    initial begin
        int k;
        rst_n = 1'b0; rst0_n = 1'b0;
        d_iv = 1'b0; d_ordy = 1'b1; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst0_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready", 64'(d_ir), 64'd1);
        chk("rst_out_valid", 64'(d_ov), 64'd0);
        chk("rst_sum", 64'(d_sum), 64'd0);
        chk("rst_cout", 64'(d_co), 64'd0);
        chk("rst_ovf", 64'(d_of), 64'd0);

        // basic add, in_ready low through RUN and DONE
        op0(16'h1234, 16'h4321, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t1_in_ready_busy", 64'(d_ir), 64'd0);
            @(negedge clk);
        end
        wait_idle0();

        // carry, signed overflow, carry-in
        op0(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_idle0();
        op0(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_idle0();
        op0(16'h0000, 16'h0000, 1'b1, 1'b0); wait_idle0();

        // subtraction with borrow and overflow
        op0(16'h0005, 16'h0007, 1'b0, 1'b1); wait_idle0();
        op0(16'h8000, 16'h0001, 1'b0, 1'b1); wait_idle0();
        op0(16'h0009, 16'h0003, 1'b1, 1'b1); wait_idle0();

        // backpressure with pending operands
        d_ordy = 1'b0;
        op0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        k = 0;
        while (!d_ov && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!d_ov) fail_now("t4_valid_timeout");
        d_a = 16'h1111; d_b = 16'h2222; d_cin = 1'b1; d_sub = 1'b1; d_iv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 64'(d_ov), 64'd1);
            chk("t4_hold_in_ready", 64'(d_ir), 64'd0);
            chk("t4_hold_sum", 64'(d_sum), 64'h8000);
            chk("t4_hold_cout", 64'(d_co), 64'd0);
            chk("t4_hold_ovf", 64'(d_of), 64'd1);
            @(negedge clk);
        end
        d_ordy = 1'b1;
        @(negedge clk);
        chk("t4_valid_fall", 64'(d_ov), 64'd0);
        chk("t4_in_ready_back", 64'(d_ir), 64'd1);
        q0.push_back(ref_model(16, 64'h1111, 64'h2222, 1'b1, 1'b1, cyc + 1));
        @(negedge clk);
        d_iv = 1'b0;
        chk("t4_pending_accepted", 64'(d_ir), 64'd0);
        wait_idle0();

        // reset during RUN
        op0(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst0_n = 1'b0;
        #1;
        chk("t5_in_ready", 64'(d_ir), 64'd1);
        chk("t5_out_valid", 64'(d_ov), 64'd0);
        chk("t5_sum", 64'(d_sum), 64'd0);
        chk("t5_cout", 64'(d_co), 64'd0);
        chk("t5_ovf", 64'(d_of), 64'd0);
        q0.delete();
        @(negedge clk);
        rst0_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_valid", 64'(d_ov), 64'd0);
        end
        op0(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_idle0();

        k = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done)
               && k < 90000) begin
            @(negedge clk);
            k++;
        end
        if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done))
            fail_now("sweep_timeout");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
